// File: rtl/wb_burst_pkg.sv
// Shared Wishbone B3 encodings and burst-master FSM types.
// Response priority (err over ack over rty) is kept here so every user resolves it the same way.
package wb_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RETRY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2,
    RSP_RTY  = 2'd3
  } rsp_e;

  // An error aborts even an acked beat; a retry only counts when nothing else answered.
  function automatic rsp_e resolve_rsp(input logic ack, input logic err, input logic rty);
    if (err)      return RSP_ERR;
    else if (ack) return RSP_ACK;
    else if (rty) return RSP_RTY;
    else          return RSP_NONE;
  endfunction

endpackage

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: one command moves 1..2^LEN_W words,
// streaming write data in and registered read data out.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,

  input  logic              wdat_valid_i,
  input  logic [DW-1:0]     wdat_i,
  output logic              wdat_ready_o,

  output logic              rdat_valid_o,
  output logic [DW-1:0]     rdat_o,
  output logic              rdat_last_o,

  output logic              done_o,
  output logic              err_o,

  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i
);

  localparam int            SW       = DW / 8;
  localparam logic [AW-1:0] ADR_STEP = AW'(SW);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DW-1:0]      rdat_q, rdat_d;
  logic               rdat_valid_q, rdat_valid_d;
  logic               rdat_last_q, rdat_last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               in_burst;
  logic               stb;
  logic               last_beat;
  rsp_e               rsp;

  assign in_burst  = (state_q == ST_BURST);
  // Writes only strobe when a data word is actually on hand; cyc stays up across the stall.
  assign stb       = in_burst & (we_q ? wdat_valid_i : 1'b1);
  assign last_beat = (rem_q == '0);
  assign rsp       = stb ? resolve_rsp(wb_ack_i, wb_err_i, wb_rty_i) : RSP_NONE;

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign wdat_ready_o = (rsp == RSP_ACK) & we_q;

  assign rdat_valid_o = rdat_valid_q;
  assign rdat_o       = rdat_q;
  assign rdat_last_o  = rdat_last_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

  assign wb_cyc_o = in_burst;
  assign wb_stb_o = stb;
  assign wb_we_o  = in_burst & we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = (in_burst & we_q) ? wdat_i : '0;
  assign wb_sel_o = {SW{in_burst}};
  assign wb_cti_o = in_burst ? (last_beat ? CTI_EOB : CTI_INC) : CTI_CLASSIC;
  assign wb_bte_o = BTE_LINEAR;

  always_comb begin
    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    rem_d        = rem_q;
    rdat_d       = rdat_q;
    rdat_valid_d = 1'b0;
    rdat_last_d  = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          rem_d   = cmd_len_i;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        unique case (rsp)
          RSP_ERR: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
          RSP_ACK: begin
            adr_d = adr_q + ADR_STEP;
            if (!we_q) begin
              rdat_valid_d = 1'b1;
              rdat_d       = wb_dat_i;
              rdat_last_d  = last_beat;
            end
            if (last_beat) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
          RSP_RTY:  state_d = ST_RETRY;
          default:  ;
        endcase
      end

      // One idle cycle with cyc low, then resume at the held address and count.
      ST_RETRY: state_d = ST_BURST;

      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      adr_q        <= '0;
      rem_q        <= '0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
      rdat_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      rem_q        <= rem_d;
      rdat_q       <= rdat_d;
      rdat_valid_q <= rdat_valid_d;
      rdat_last_q  <= rdat_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a Wishbone slave model checks each beat against a queue,
// and a separate monitor pops expected read beats and done/err pulses as the DUT presents them.
module tb_wb_burst_master;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic             cmd_we_i = 1'b0;
  logic [AW-1:0]    cmd_adr_i = '0;
  logic [LEN_W-1:0] cmd_len_i = '0;
  logic             wdat_valid_i = 1'b0;
  logic [DW-1:0]    wdat_i = '0;
  logic             wdat_ready_o;
  logic             rdat_valid_o;
  logic [DW-1:0]    rdat_o;
  logic             rdat_last_o;
  logic             done_o;
  logic             err_o;
  logic [AW-1:0]    wb_adr_o;
  logic [DW-1:0]    wb_dat_o;
  logic [DW/8-1:0]  wb_sel_o;
  logic             wb_we_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;
  logic [DW-1:0]    wb_dat_i = '0;
  logic             wb_ack_i = 1'b0;
  logic             wb_err_i = 1'b0;
  logic             wb_rty_i = 1'b0;

  always #5 clk = ~clk;

  wb_burst_master #(.AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_i(wdat_i), .wdat_ready_o(wdat_ready_o),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_last_o(rdat_last_o),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } rd_t;

  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  beat_t       exp_beat[$];
  rd_t         exp_rd[$];
  int          exp_st[$];
  logic [31:0] wq[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Slave behaviour for the current burst (beat indices count completed beats).
  int err_at = -1, rty_at = -1, errack_at = -1, gap_after = -1, gap_len = 0;
  int beat_idx = 0, gap_cnt = 0, rty_gap = 0, stall_cnt = 0, wr_pulses = 0;
  bit rty_used = 1'b0, rty_pend = 1'b0, cur_we = 1'b0;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %h, nothing expected", name, act);
  endtask

  task automatic cfg(input int e, input int r, input int ea, input int ga, input int gl);
    err_at = e; rty_at = r; errack_at = ea; gap_after = ga; gap_len = gl;
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [2:0] c, input logic w, input logic [31:0] d);
    beat_t b;
    b.adr = a; b.cti = c; b.we = w; b.dat = d;
    exp_beat.push_back(b);
  endtask

  task automatic push_rd(input logic [31:0] a, input logic l);
    rd_t r;
    r.dat = rd_data(a); r.last = l;
    exp_rd.push_back(r);
  endtask

  task automatic slave_loop();
    beat_t b;
    forever begin
      @(negedge clk);
      if (gap_cnt > 0) begin
        wdat_valid_i = 1'b0;
        gap_cnt--;
      end else if (wq.size() > 0) begin
        wdat_valid_i = 1'b1;
        wdat_i       = wq[0];
      end else begin
        wdat_valid_i = 1'b0;
        wdat_i       = '0;
      end
      #1;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
      if (cmd_valid_i && cmd_ready_o) begin
        beat_idx = 0; rty_used = 1'b0; rty_pend = 1'b0; stall_cnt = 0; wr_pulses = 0;
      end
      if (rty_pend) begin
        if (!wb_cyc_o) rty_gap++;
        else begin
          check("retry_gap_cycles", 32'(rty_gap), 32'd1);
          rty_pend = 1'b0;
        end
      end
      if (wb_cyc_o && !wb_stb_o) begin
        stall_cnt++;
        if (exp_beat.size() > 0) begin
          check("stall_adr", wb_adr_o, exp_beat[0].adr);
          check("stall_cti", 32'(wb_cti_o), 32'(exp_beat[0].cti));
        end
      end
      if (wb_cyc_o && wb_stb_o) begin
        if (exp_beat.size() == 0) flag("unexpected_beat_adr", wb_adr_o);
        else begin
          b = exp_beat[0];
          check("beat_adr", wb_adr_o, b.adr);
          check("beat_cti", 32'(wb_cti_o), 32'(b.cti));
          check("beat_we", 32'(wb_we_o), 32'(b.we));
          check("beat_sel", 32'(wb_sel_o), 32'h0000_000F);
          check("beat_bte", 32'(wb_bte_o), 32'd0);
          if (b.we) check("beat_wdat", wb_dat_o, b.dat);
        end
        if (beat_idx == errack_at) begin
          wb_ack_i = 1'b1; wb_err_i = 1'b1;
          if (exp_beat.size() > 0) void'(exp_beat.pop_front());
        end else if (beat_idx == err_at) begin
          wb_err_i = 1'b1;
          if (exp_beat.size() > 0) void'(exp_beat.pop_front());
        end else if (beat_idx == rty_at && !rty_used) begin
          wb_rty_i = 1'b1; rty_used = 1'b1; rty_pend = 1'b1; rty_gap = 0;
        end else begin
          wb_ack_i = 1'b1;
          wb_dat_i = rd_data(wb_adr_o);
          if (exp_beat.size() > 0) void'(exp_beat.pop_front());
          beat_idx++;
          if (wb_we_o) begin
            if (wq.size() > 0) void'(wq.pop_front());
            if (beat_idx == gap_after) gap_cnt = gap_len;
          end
        end
      end
      #1;
      if (wdat_ready_o) wr_pulses++;
    end
  endtask

  task automatic monitor_loop();
    rd_t r;
    int  s;
    forever begin
      @(negedge clk);
      if (rdat_valid_o) begin
        if (exp_rd.size() == 0) flag("unexpected_rdat", rdat_o);
        else begin
          r = exp_rd.pop_front();
          check("rdat", rdat_o, r.dat);
          check("rdat_last", 32'(rdat_last_o), 32'(r.last));
        end
      end
      if (done_o || err_o) begin
        if (exp_st.size() == 0) flag("unexpected_status", {30'd0, err_o, done_o});
        else begin
          s = exp_st.pop_front();
          check("status_kind", {30'd0, err_o, done_o}, 32'(s));
          check("ready_at_end", 32'(cmd_ready_o), 32'd1);
          if (done_o && !cur_we) check("done_with_last_rdat", 32'(rdat_valid_o & rdat_last_o), 32'd1);
        end
      end
    end
  endtask

  task automatic issue(input bit we, input logic [31:0] adr, input logic [3:0] len);
    int t;
    t = 0;
    cur_we = we;
    @(negedge clk);
    while (!cmd_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_before_cmd", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("cyc_after_accept", 32'(wb_cyc_o), 32'd1);
    check("ready_low_in_burst", 32'(cmd_ready_o), 32'd0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_st.size() != 0 || !cmd_ready_o) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    check("status_pending", 32'(exp_st.size()), 32'd0);
    check("rdat_pending", 32'(exp_rd.size()), 32'd0);
    check("beats_pending", 32'(exp_beat.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    fork
      monitor_loop();
      slave_loop();
    join_none

    #1 rst = 1'b1;
    #2;
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    check("rst_ctrl_outputs",
          32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_sel_o,
               rdat_valid_o, rdat_last_o, done_o, err_o, wdat_ready_o}), 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_wdat", wb_dat_o, 32'd0);
    check("rst_rdat", rdat_o, 32'd0);
    check("rst_cmd_ready_held", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single-beat read: one EOB cycle, data/last/done together.
    cfg(-1, -1, -1, -1, 0);
    push_beat(32'h100, 3'b111, 1'b0, 32'h0);
    push_rd(32'h100, 1'b1);
    exp_st.push_back(ST_DONE);
    issue(1'b0, 32'h100, 4'd0);
    wait_done();

    // Four-beat write with continuous data.
    cfg(-1, -1, -1, -1, 0);
    for (int i = 0; i < 4; i++) begin
      wq.push_back(32'hA000_0000 + 32'(i));
      push_beat(32'h200 + 32'(4 * i), (i == 3) ? 3'b111 : 3'b010, 1'b1, 32'hA000_0000 + 32'(i));
    end
    exp_st.push_back(ST_DONE);
    issue(1'b1, 32'h200, 4'd3);
    wait_done();
    check("wr_ready_pulses", 32'(wr_pulses), 32'd4);
    check("wr_no_stall", 32'(stall_cnt), 32'd0);

    // Same write with a two-cycle data gap after beat 1.
    cfg(-1, -1, -1, 1, 2);
    for (int i = 0; i < 4; i++) begin
      wq.push_back(32'hB000_0000 + 32'(i));
      push_beat(32'h200 + 32'(4 * i), (i == 3) ? 3'b111 : 3'b010, 1'b1, 32'hB000_0000 + 32'(i));
    end
    exp_st.push_back(ST_DONE);
    issue(1'b1, 32'h200, 4'd3);
    wait_done();
    check("gap_stall_cycles", 32'(stall_cnt), 32'd2);
    check("gap_ready_pulses", 32'(wr_pulses), 32'd4);

    // Eight-beat read aborted by err on the third beat.
    cfg(2, -1, -1, -1, 0);
    for (int i = 0; i < 3; i++) push_beat(32'h500 + 32'(4 * i), 3'b010, 1'b0, 32'h0);
    push_rd(32'h500, 1'b0);
    push_rd(32'h504, 1'b0);
    exp_st.push_back(ST_ERR);
    issue(1'b0, 32'h500, 4'd7);
    wait_done();

    // Four-beat read with a retry on the second beat.
    cfg(-1, 1, -1, -1, 0);
    push_beat(32'h300, 3'b010, 1'b0, 32'h0);
    push_beat(32'h304, 3'b010, 1'b0, 32'h0);
    push_beat(32'h308, 3'b010, 1'b0, 32'h0);
    push_beat(32'h30C, 3'b111, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) push_rd(32'h300 + 32'(4 * i), i == 3);
    exp_st.push_back(ST_DONE);
    issue(1'b0, 32'h300, 4'd3);
    wait_done();
    check("retry_resolved", 32'(rty_pend), 32'd0);

    // Address wraps past the top of the space.
    cfg(-1, -1, -1, -1, 0);
    push_beat(32'hFFFF_FFFC, 3'b010, 1'b0, 32'h0);
    push_beat(32'h0000_0000, 3'b111, 1'b0, 32'h0);
    push_rd(32'hFFFF_FFFC, 1'b0);
    push_rd(32'h0000_0000, 1'b1);
    exp_st.push_back(ST_DONE);
    issue(1'b0, 32'hFFFF_FFFC, 4'd1);
    wait_done();

    // ack and err together: err wins, no read data.
    cfg(-1, -1, 0, -1, 0);
    push_beat(32'h600, 3'b010, 1'b0, 32'h0);
    exp_st.push_back(ST_ERR);
    issue(1'b0, 32'h600, 4'd2);
    wait_done();

    // Reset during beat 3 of an eight-beat write.
    cfg(-1, -1, -1, -1, 0);
    for (int i = 0; i < 8; i++) wq.push_back(32'hC000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) push_beat(32'h400 + 32'(4 * i), 3'b010, 1'b1, 32'hC000_0000 + 32'(i));
    issue(1'b1, 32'h400, 4'd7);
    t = 0;
    while (beat_idx < 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_test_reached_beat3", 32'(beat_idx), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    check("rst_mid_pulses", 32'({done_o, err_o, wdat_ready_o}), 32'd0);
    wq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_release_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_beats_pending", 32'(exp_beat.size()), 32'd0);

    // Recovery: a normal two-beat read after the reset.
    cfg(-1, -1, -1, -1, 0);
    push_beat(32'h700, 3'b010, 1'b0, 32'h0);
    push_beat(32'h704, 3'b111, 1'b0, 32'h0);
    push_rd(32'h700, 1'b0);
    push_rd(32'h704, 1'b1);
    exp_st.push_back(ST_DONE);
    issue(1'b0, 32'h700, 4'd1);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
